seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, sequential successor to the datapath ALU, with a valid/ready handshake on both input and output.
- Logic, add/sub, shift, rotate and compare ops complete in one cycle.
- Signed multiply and divide run on an iterative shift-add / restoring unit and take WIDTH cycles.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid instead of assuming single-cycle completion.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a power of two and at least 4.
- SHW, $clog2(WIDTH), derived; width of the effective shift/rotate amount; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- funct  in  4  opcode: 1111 add, 1110 sub, 1101 and, 1100 or, 0001 mul, 0010 div, 1010 shl, 1011 shr, 1000 rotl, 1001 rotr, 0011 blt, 0100 bgt, 0101 beq.
- a  in  WIDTH  signed operand 1.
- b  in  WIDTH  signed operand 2; shift/rotate amount when treated as unsigned.
- out_valid  out  1  result registers hold a completed operation.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  low product, quotient or ALU result.
- hi  out  WIDTH  high product or remainder; 0 for all other ops.
- branch  out  1  compare outcome; 0 for non-compare ops.
- div_by_zero  out  1  set with a div whose b==0; 0 otherwise.

Behaviour:
- Reset (async, any state):
  - state goes to IDLE; iteration counter is cleared.
  - result, hi, branch, div_by_zero, out_valid all go to 0.
  - An in-flight mul/div is discarded and produces no output.
- States:
  - IDLE: in_ready=1. On in_valid, a/b/funct are captured. Single-cycle ops go to DONE. 0001 goes to MUL. 0010 with b!=0 goes to DIV. 0010 with b==0 goes to DONE with the div-by-zero values below.
  - MUL / DIV: one iteration per cycle for WIDTH cycles. The counter counts WIDTH-1 down to 0; at 0 the unit goes to DONE. in_ready=0; in_valid is ignored.
  - DONE: out_valid=1 and all outputs are held stable. On out_ready the unit goes to IDLE and out_valid drops next cycle; outputs keep their values until the next completion.
- Timing:
  - Latency, accept edge to out_valid: 1 cycle for single-cycle ops; WIDTH+1 cycles for mul/div.
  - No back-to-back accept: a new request is accepted no earlier than the cycle after out_ready.
- Arithmetic:
  - add/sub: wrap modulo 2^WIDTH; no overflow flag.
  - mul: {hi,result} = signed 2*WIDTH-bit product of a and b. Operands are made positive, the magnitudes are multiplied, and the product is negated if the signs differ.
  - div: quotient truncates toward zero; remainder takes the sign of a, so a == q*b + r. The most-negative value divided by -1 gives result = most-negative, hi = 0.
  - div by zero: result = all ones, hi = a, div_by_zero = 1, one-cycle completion.
- Shifts and rotates:
  - shl/shr: b is unsigned. If b >= WIDTH, result = 0. shr is a logical shift.
  - rotl/rotr: amount = b[SHW-1:0], i.e. b mod WIDTH; amount 0 returns a unchanged.
- Compares: blt/bgt/beq are signed; result = 0 and hi = 0.
- Any other funct value: completes in one cycle with all outputs 0.
- Simultaneous events: in IDLE with in_valid, the capture happens regardless of out_ready. out_ready outside DONE is ignored.

Decomposition:
- Package seq_alu_pkg holds:
  - the funct localparams (FN_ADD … FN_BEQ);
  - the state enum IDLE/MUL/DIV/DONE.
- Sub-module seq_alu_muldiv holds the iterative unit:
  - ports: start, is_div, a, b, busy, done, q_lo, r_hi;
  - it owns the sign fix-up and the iteration counter.
- The top level owns the handshake FSM, the single-cycle datapath and the output registers.

Test Plan:
- Add at WIDTH=16: a=0x7FFF, b=0x0001 -> result=0x8000, hi=0, branch=0; out_valid one cycle after accept.
- Mul at WIDTH=16: a=-3, b=5 -> {hi,result}=0xFFFF_FFF1; out_valid exactly 17 cycles after accept; in_ready=0 throughout.
- Div: a=-7, b=2 -> result=0xFFFD (-3), hi=0xFFFF (-1). Then a=5, b=0 -> result=0xFFFF, hi=0x0005, div_by_zero=1 after 1 cycle.
- Rotate at WIDTH=16: rotl a=0x8001, b=17 -> 0x0003. Then shl a=0x0001, b=16 -> 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is not accepted; accepted on the first cycle after out_ready.
- Reset mid-div: assert rst on iteration 8 -> out_valid=0 and in_ready=1 immediately, no stale result appears. Rerun at WIDTH=32 with mul 0x7FFFFFFF*2 -> hi=0, result=0xFFFFFFFE.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module      : seq_alu_pkg
// Description : Opcodes and handshake FSM states shared by the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

   localparam logic [3:0] FN_ADD  = 4'b1111;
   localparam logic [3:0] FN_SUB  = 4'b1110;
   localparam logic [3:0] FN_AND  = 4'b1101;
   localparam logic [3:0] FN_OR   = 4'b1100;
   localparam logic [3:0] FN_MUL  = 4'b0001;
   localparam logic [3:0] FN_DIV  = 4'b0010;
   localparam logic [3:0] FN_SHL  = 4'b1010;
   localparam logic [3:0] FN_SHR  = 4'b1011;
   localparam logic [3:0] FN_ROTL = 4'b1000;
   localparam logic [3:0] FN_ROTR = 4'b1001;
   localparam logic [3:0] FN_BLT  = 4'b0011;
   localparam logic [3:0] FN_BGT  = 4'b0100;
   localparam logic [3:0] FN_BEQ  = 4'b0101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
// ============================================================================
// Module      : seq_alu_muldiv
// Description : Iterative signed shift-add multiplier / restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_muldiv #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q_lo,
   output logic [WIDTH-1:0] r_hi
);

   localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);

   logic [SHW-1:0]     r_cnt;
   logic               r_busy;
   logic               r_is_div;
   logic               r_neg_p;
   logic               r_neg_a;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic [WIDTH-1:0]   r_m;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_sh;
   logic [WIDTH:0]     w_tr;
   logic [WIDTH-1:0]   w_hi_nx;
   logic [WIDTH-1:0]   w_lo_nx;
   logic [2*WIDTH-1:0] w_prod;

   assign w_abs_a = a[WIDTH-1] ? -a : a;
   assign w_abs_b = b[WIDTH-1] ? -b : b;

   // |a| sits in the low accumulator for both ops: multiplier bits shift out
   // of it, dividend bits shift out of its top while quotient bits shift in.
   always_comb begin
      w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
      w_sh    = {r_acc_hi, r_acc_lo[WIDTH-1]};
      w_tr    = w_sh - {1'b0, r_m};
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_acc_lo[WIDTH-1:1]};
      if (r_is_div) begin
         w_hi_nx = w_tr[WIDTH] ? w_sh[WIDTH-1:0] : w_tr[WIDTH-1:0];
         w_lo_nx = {r_acc_lo[WIDTH-2:0], ~w_tr[WIDTH]};
      end
   end

   // Results are taken from the final iteration's next-state values so the
   // top can register them on the same edge as the last iteration.
   always_comb begin
      w_prod = {w_hi_nx, w_lo_nx};
      if (r_neg_p) w_prod = -w_prod;
      q_lo = w_prod[WIDTH-1:0];
      r_hi = w_prod[2*WIDTH-1:WIDTH];
      if (r_is_div) begin
         q_lo = r_neg_p ? -w_lo_nx : w_lo_nx;
         r_hi = r_neg_a ? -w_hi_nx : w_hi_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_p  <= 1'b0;
         r_neg_a  <= 1'b0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_m      <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= c_last;
         r_is_div <= is_div;
         r_neg_p  <= a[WIDTH-1] ^ b[WIDTH-1];
         r_neg_a  <= a[WIDTH-1];
         r_acc_hi <= '0;
         r_acc_lo <= w_abs_a;
         r_m      <= w_abs_b;
      end else if (r_busy) begin
         r_acc_hi <= w_hi_nx;
         r_acc_lo <= w_lo_nx;
         if (r_cnt == '0) r_busy <= 1'b0;
         else             r_cnt  <= r_cnt - SHW'(1);
      end
   end

   assign busy = r_busy;
   assign done = r_busy && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with valid/ready handshake; iterative mul/div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             branch,
   output logic             div_by_zero
);

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_hi;
   logic             r_branch;
   logic             r_dz;

   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_hi;
   logic             w_br;
   logic             w_dz;
   logic [SHW-1:0]   w_amt;
   logic             w_big;
   logic             w_md_start;
   logic             w_md_busy;
   logic             w_md_done;
   logic [WIDTH-1:0] w_md_q;
   logic [WIDTH-1:0] w_md_r;

   assign w_amt = b[SHW-1:0];
   assign w_big = |b[WIDTH-1:SHW];

   always_comb begin
      w_res = '0;
      w_hi  = '0;
      w_br  = 1'b0;
      w_dz  = 1'b0;
      case (funct)
         FN_ADD:  w_res = a + b;
         FN_SUB:  w_res = a - b;
         FN_AND:  w_res = a & b;
         FN_OR:   w_res = a | b;
         FN_SHL:  w_res = w_big ? '0 : (a << w_amt);
         FN_SHR:  w_res = w_big ? '0 : (a >> w_amt);
         FN_ROTL: w_res = (a << w_amt) | (a >> (WIDTH - 32'(w_amt)));
         FN_ROTR: w_res = (a >> w_amt) | (a << (WIDTH - 32'(w_amt)));
         FN_BLT:  w_br  = $signed(a) < $signed(b);
         FN_BGT:  w_br  = $signed(a) > $signed(b);
         FN_BEQ:  w_br  = (a == b);
         // Only reached with b == 0; a non-zero divisor goes iterative.
         FN_DIV: begin
            w_res = '1;
            w_hi  = a;
            w_dz  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_md_start = (r_state == IDLE) && in_valid && !w_md_busy &&
                       ((funct == FN_MUL) || ((funct == FN_DIV) && (b != '0)));

   seq_alu_muldiv #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (w_md_start),
      .is_div (funct == FN_DIV),
      .a      (a),
      .b      (b),
      .busy   (w_md_busy),
      .done   (w_md_done),
      .q_lo   (w_md_q),
      .r_hi   (w_md_r)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_hi        <= '0;
         r_branch    <= 1'b0;
         r_dz        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_in_ready <= 1'b0;
               if (w_md_start) begin
                  r_state <= (funct == FN_DIV) ? DIV : MUL;
               end else begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_res;
                  r_hi        <= w_hi;
                  r_branch    <= w_br;
                  r_dz        <= w_dz;
               end
            end
            MUL, DIV: if (w_md_done) begin
               r_state     <= DONE;
               r_out_valid <= 1'b1;
               r_result    <= w_md_q;
               r_hi        <= w_md_r;
               r_branch    <= 1'b0;
               r_dz        <= 1'b0;
            end
            DONE: if (out_ready) begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign result      = r_result;
   assign hi          = r_hi;
   assign branch      = r_branch;
   assign div_by_zero = r_dz;

endmodule

`default_nettype wire
